// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Pipelined control unit for the MIPS core. Decodes the instruction in ID,
// carries the resulting control word through the EX, MEM and WB stage
// registers, detects load-use and multiply-busy hazards, and tracks the
// latency of a multi-cycle MULTU.
//
// Parameters:
//   MD_LAT  MULTU execution latency in cycles (>= 1)
//   HAZ_EN  1 enables the load-use interlock, 0 leaves scheduling to software
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   instr_id, id_valid     instruction in ID and its valid flag
//   br_taken_ex            compare result for the BEQ held in EX
//   ext_op, npc_op         ID immediate extension and next-PC select
//   stall, flush_if        freeze PC and IF/ID, squash IF/ID
//   ex_alu_op, ex_alu_src  EX ALU control
//   ex_is_beq, ex_md_start EX holds a valid BEQ / MULTU
//   mem_re, mem_we         MEM read and write enables
//   wb_we, wb_addr, wb_sel register write-back control
//   md_busy                a MULTU is still in progress

module ctrl_pipeline #(
  parameter int MD_LAT = 4,
  parameter bit HAZ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_id,
  input  logic        id_valid,
  input  logic        br_taken_ex,
  output logic [1:0]  ext_op,
  output logic [1:0]  npc_op,
  output logic        stall,
  output logic        flush_if,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_is_beq,
  output logic        ex_md_start,
  output logic        mem_re,
  output logic        mem_we,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [1:0]  wb_sel,
  output logic        md_busy
);

  localparam int CW = $clog2(MD_LAT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd4;
  localparam logic [2:0] ALU_SRA = 3'd5;
  localparam logic [2:0] ALU_LUI = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;

  // Control word carried by every stage register; all-zero is a bubble.
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       is_beq;
    logic       md_start;
    logic       mem_re;
    logic       mem_we;
    logic       wb_we;
    logic [4:0] wb_addr;
    logic [1:0] wb_sel;
  } ctrl_t;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = instr_id[31:26];
  assign rs    = instr_id[25:21];
  assign rt    = instr_id[20:16];
  assign rd    = instr_id[15:11];
  assign funct = instr_id[5:0];

  ctrl_t         dec, ex_q, mem_q, wb_q;
  logic [1:0]    dec_ext, dec_npc;
  logic          use_rs, use_rt, is_jump, is_md, wr;
  logic          br_flush, load_use, md_hazard;
  logic [CW-1:0] md_cnt;

  // ID decode. Unrecognised encodings and invalid slots leave everything 0.
  always_comb begin
    dec     = '0;
    dec_ext = 2'd0;
    dec_npc = 2'd0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_jump = 1'b0;
    is_md   = 1'b0;
    wr      = 1'b0;
    if (id_valid) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU, FN_SUBU, FN_SLL, FN_SRL, FN_SRA: begin
              dec.valid   = 1'b1;
              use_rs      = 1'b1;
              use_rt      = 1'b1;
              wr          = 1'b1;
              dec.wb_addr = rd;
              case (funct)
                FN_SUBU: dec.alu_op = ALU_SUB;
                FN_SLL:  dec.alu_op = ALU_SLL;
                FN_SRL:  dec.alu_op = ALU_SRL;
                FN_SRA:  dec.alu_op = ALU_SRA;
                default: dec.alu_op = ALU_ADD;
              endcase
            end
            FN_JR: begin
              dec.valid = 1'b1;
              use_rs    = 1'b1;
              is_jump   = 1'b1;
              dec_npc   = 2'd3;
            end
            FN_MULTU: begin
              dec.valid    = 1'b1;
              use_rs       = 1'b1;
              is_md        = 1'b1;
              dec.md_start = 1'b1;
            end
            FN_MFLO: begin
              dec.valid   = 1'b1;
              use_rs      = 1'b1;
              is_md       = 1'b1;
              wr          = 1'b1;
              dec.wb_addr = rd;
              dec.wb_sel  = 2'd3;
            end
            default: ;
          endcase
        end
        OP_ORI: begin
          dec.valid   = 1'b1;
          dec.alu_op  = ALU_OR;
          dec.alu_src = 1'b1;
          dec_ext     = 2'd1;
          use_rs      = 1'b1;
          wr          = 1'b1;
          dec.wb_addr = rt;
        end
        OP_LUI: begin
          dec.valid   = 1'b1;
          dec.alu_op  = ALU_LUI;
          dec.alu_src = 1'b1;
          dec_ext     = 2'd2;
          wr          = 1'b1;
          dec.wb_addr = rt;
        end
        OP_LW: begin
          dec.valid   = 1'b1;
          dec.alu_src = 1'b1;
          dec.mem_re  = 1'b1;
          use_rs      = 1'b1;
          wr          = 1'b1;
          dec.wb_addr = rt;
          dec.wb_sel  = 2'd1;
        end
        OP_SW: begin
          dec.valid   = 1'b1;
          dec.alu_src = 1'b1;
          dec.mem_we  = 1'b1;
          use_rs      = 1'b1;
          use_rt      = 1'b1;
        end
        OP_BEQ: begin
          dec.valid  = 1'b1;
          dec.alu_op = ALU_EQ;
          dec.is_beq = 1'b1;
          use_rs     = 1'b1;
          use_rt     = 1'b1;
        end
        OP_J: begin
          dec.valid = 1'b1;
          is_jump   = 1'b1;
          dec_npc   = 2'd2;
        end
        OP_JAL: begin
          dec.valid   = 1'b1;
          is_jump     = 1'b1;
          dec_npc     = 2'd2;
          wr          = 1'b1;
          dec.wb_addr = 5'd31;
          dec.wb_sel  = 2'd2;
        end
        default: ;
      endcase
    end
    dec.wb_we = wr && (dec.wb_addr != 5'd0);
  end

  // Hazard resolution. A taken BEQ in EX overrides everything decoded in ID.
  // MFLO/MULTU also wait while the MULTU is still in EX, because the counter
  // only becomes busy on the following cycle.
  always_comb begin
    br_flush  = ex_q.is_beq && br_taken_ex;
    load_use  = HAZ_EN && ex_q.mem_re && (ex_q.wb_addr != 5'd0) &&
                ((use_rs && (rs == ex_q.wb_addr)) ||
                 (use_rt && (rt == ex_q.wb_addr)));
    md_hazard = is_md && (md_busy || ex_q.md_start);
    stall     = !br_flush && (load_use || md_hazard);
    flush_if  = br_flush || (is_jump && !stall);
    npc_op    = br_flush ? 2'd1 : dec_npc;
    ext_op    = dec_ext;
  end

  // Stage registers and the MULTU latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      md_cnt <= '0;
    end else begin
      ex_q  <= (stall || br_flush) ? '0 : dec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (ex_q.md_start)
        md_cnt <= CW'(MD_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CW'(1);
    end
  end

  assign ex_alu_op   = ex_q.alu_op;
  assign ex_alu_src  = ex_q.alu_src;
  assign ex_is_beq   = ex_q.is_beq;
  assign ex_md_start = ex_q.md_start;
  assign mem_re      = mem_q.mem_re;
  assign mem_we      = mem_q.mem_we;
  assign wb_we       = wb_q.wb_we;
  assign wb_addr     = wb_q.wb_addr;
  assign wb_sel      = wb_q.wb_sel;
  assign md_busy     = (md_cnt != '0);

  logic unused_bits;
  assign unused_bits = ^{wb_q.valid, wb_q.alu_op, wb_q.alu_src, wb_q.is_beq,
                         wb_q.md_start, wb_q.mem_re, wb_q.mem_we, instr_id[10:6]};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Directed scenarios followed by random instruction streams, checked every
// cycle against an instruction-level model of the control pipeline.

module tb_ctrl_pipeline;

  localparam int MD_LAT = 4;

  typedef enum int {
    K_NOP, K_ADDU, K_SUBU, K_SLL, K_SRL, K_SRA, K_JR, K_MULTU, K_MFLO,
    K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILLEGAL
  } kind_t;

  typedef struct {
    kind_t       kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } ins_t;

  logic        clk, rst;
  logic [31:0] instr_id;
  logic        id_valid, br_taken_ex;
  logic [1:0]  ext_op, npc_op, wb_sel;
  logic        stall, flush_if, ex_alu_src, ex_is_beq, ex_md_start;
  logic [2:0]  ex_alu_op;
  logic        mem_re, mem_we, wb_we, md_busy;
  logic [4:0]  wb_addr;

  logic        nh_stall;
  logic [1:0]  unused_ext_op, unused_npc_op, unused_wb_sel;
  logic        unused_flush_if, unused_alu_src, unused_is_beq, unused_md_start;
  logic [2:0]  unused_alu_op;
  logic        unused_mem_re, unused_mem_we, unused_wb_we, unused_md_busy;
  logic [4:0]  unused_wb_addr;

  int total = 0;
  int bad   = 0;

  // Model state: the instruction in each stage plus remaining MULTU cycles.
  ins_t m_id, m_ex, m_mem, m_wb;
  int   md_left;
  bit   e_br, e_stall, e_flush;
  int   e_npc;

  ctrl_pipeline #(.MD_LAT(MD_LAT), .HAZ_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
    .br_taken_ex(br_taken_ex), .ext_op(ext_op), .npc_op(npc_op),
    .stall(stall), .flush_if(flush_if), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_is_beq(ex_is_beq), .ex_md_start(ex_md_start),
    .mem_re(mem_re), .mem_we(mem_we), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .md_busy(md_busy)
  );

  ctrl_pipeline #(.MD_LAT(MD_LAT), .HAZ_EN(1'b0)) dut_nohaz (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
    .br_taken_ex(br_taken_ex), .ext_op(unused_ext_op), .npc_op(unused_npc_op),
    .stall(nh_stall), .flush_if(unused_flush_if), .ex_alu_op(unused_alu_op),
    .ex_alu_src(unused_alu_src), .ex_is_beq(unused_is_beq),
    .ex_md_start(unused_md_start), .mem_re(unused_mem_re),
    .mem_we(unused_mem_we), .wb_we(unused_wb_we), .wb_addr(unused_wb_addr),
    .wb_sel(unused_wb_sel), .md_busy(unused_md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ins_t mk(kind_t k, int rs, int rt, int rd);
    ins_t i;
    i.kind = k;
    i.rs   = 5'(rs);
    i.rt   = 5'(rt);
    i.rd   = 5'(rd);
    i.imm  = 32'h0;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(K_NOP, 0, 0, 0);
  endfunction

  function automatic logic [31:0] encode(ins_t i);
    logic [31:0] w;
    w = i.imm;
    case (i.kind)
      K_ADDU:  w = {6'b0, i.rs, i.rt, i.rd, 5'd0, 6'b100001};
      K_SUBU:  w = {6'b0, i.rs, i.rt, i.rd, 5'd0, 6'b100011};
      K_SLL:   w = {6'b0, i.rs, i.rt, i.rd, i.imm[4:0], 6'b000000};
      K_SRL:   w = {6'b0, i.rs, i.rt, i.rd, i.imm[4:0], 6'b000010};
      K_SRA:   w = {6'b0, i.rs, i.rt, i.rd, i.imm[4:0], 6'b000011};
      K_JR:    w = {6'b0, i.rs, 15'd0, 6'b001000};
      K_MULTU: w = {6'b0, i.rs, i.rt, 10'd0, 6'b011001};
      K_MFLO:  w = {16'd0, i.rd, 5'd0, 6'b010010};
      K_ORI:   w = {6'b001101, i.rs, i.rt, i.imm[15:0]};
      K_LUI:   w = {6'b001111, 5'd0, i.rt, i.imm[15:0]};
      K_LW:    w = {6'b100011, i.rs, i.rt, i.imm[15:0]};
      K_SW:    w = {6'b101011, i.rs, i.rt, i.imm[15:0]};
      K_BEQ:   w = {6'b000100, i.rs, i.rt, i.imm[15:0]};
      K_J:     w = {6'b000010, i.imm[25:0]};
      K_JAL:   w = {6'b000011, i.imm[25:0]};
      K_ILLEGAL: w = i.imm[0] ? {6'b111111, i.imm[25:0]}
                              : {6'b0, i.imm[25:6], 6'b100000};
      default: w = i.imm;
    endcase
    return w;
  endfunction

  // Instruction semantics, one table per output field.
  function automatic int alu_of(kind_t k);
    case (k)
      K_SUBU: return 1;
      K_ORI:  return 2;
      K_SLL:  return 3;
      K_SRL:  return 4;
      K_SRA:  return 5;
      K_LUI:  return 6;
      K_BEQ:  return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int src_of(kind_t k);
    return (k inside {K_ORI, K_LUI, K_LW, K_SW}) ? 1 : 0;
  endfunction

  function automatic int sel_of(kind_t k);
    case (k)
      K_LW:   return 1;
      K_JAL:  return 2;
      K_MFLO: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int ext_of(kind_t k);
    case (k)
      K_ORI: return 1;
      K_LUI: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int npc_of(kind_t k);
    case (k)
      K_J, K_JAL: return 2;
      K_JR:       return 3;
      default:    return 0;
    endcase
  endfunction

  function automatic bit uses_rs(kind_t k);
    return k inside {K_ADDU, K_SUBU, K_SLL, K_SRL, K_SRA, K_JR, K_MULTU,
                     K_MFLO, K_ORI, K_LW, K_SW, K_BEQ};
  endfunction

  function automatic bit uses_rt(kind_t k);
    return k inside {K_ADDU, K_SUBU, K_SLL, K_SRL, K_SRA, K_SW, K_BEQ};
  endfunction

  function automatic int dest_of(ins_t i);
    case (i.kind)
      K_ADDU, K_SUBU, K_SLL, K_SRL, K_SRA, K_MFLO: return int'(i.rd);
      K_ORI, K_LUI, K_LW:                          return int'(i.rt);
      K_JAL:                                       return 31;
      default:                                     return -1;
    endcase
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic computeComb();
    bit load_use, md_haz;
    e_br     = (m_ex.kind == K_BEQ) && (br_taken_ex === 1'b1);
    load_use = (m_ex.kind == K_LW) && (m_ex.rt != 5'd0) &&
               ((uses_rs(m_id.kind) && m_id.rs == m_ex.rt) ||
                (uses_rt(m_id.kind) && m_id.rt == m_ex.rt));
    md_haz   = (m_id.kind inside {K_MULTU, K_MFLO}) &&
               (md_left > 0 || m_ex.kind == K_MULTU);
    e_stall  = !e_br && (load_use || md_haz);
    e_flush  = e_br || ((m_id.kind inside {K_J, K_JAL, K_JR}) && !e_stall);
    e_npc    = e_br ? 1 : npc_of(m_id.kind);
  endtask

  task automatic checkOutput();
    int d;
    d = dest_of(m_wb);
    checkField("ext_op",      32'(ext_op),      32'(ext_of(m_id.kind)));
    checkField("npc_op",      32'(npc_op),      32'(e_npc));
    checkField("stall",       32'(stall),       32'(e_stall));
    checkField("flush_if",    32'(flush_if),    32'(e_flush));
    checkField("ex_alu_op",   32'(ex_alu_op),   32'(alu_of(m_ex.kind)));
    checkField("ex_alu_src",  32'(ex_alu_src),  32'(src_of(m_ex.kind)));
    checkField("ex_is_beq",   32'(ex_is_beq),   32'(m_ex.kind == K_BEQ));
    checkField("ex_md_start", 32'(ex_md_start), 32'(m_ex.kind == K_MULTU));
    checkField("mem_re",      32'(mem_re),      32'(m_mem.kind == K_LW));
    checkField("mem_we",      32'(mem_we),      32'(m_mem.kind == K_SW));
    checkField("wb_we",       32'(wb_we),       32'(d > 0));
    checkField("wb_addr",     32'(wb_addr),     (d > 0) ? 32'(d) : 32'd0);
    checkField("wb_sel",      32'(wb_sel),      32'(sel_of(m_wb.kind)));
    checkField("md_busy",     32'(md_busy),     32'(md_left > 0));
  endtask

  // Drive one ID slot shortly after the rising edge and check at the falling edge.
  task automatic applyStimulus(input ins_t i, input bit valid, input bit br);
    logic [31:0] w;
    w           = encode(i);
    instr_id    = w;
    id_valid    = valid;
    br_taken_ex = br;
    m_id        = i;
    m_id.rs     = w[25:21];
    m_id.rt     = w[20:16];
    m_id.rd     = w[15:11];
    if (!valid) m_id.kind = K_NOP;
    computeComb();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    if (m_ex.kind == K_MULTU) md_left = MD_LAT;
    else if (md_left > 0)     md_left--;
    m_ex  = (e_stall || e_br) ? bubble() : m_id;
    #1;
  endtask

  task automatic modelReset();
    m_ex    = bubble();
    m_mem   = bubble();
    m_wb    = bubble();
    md_left = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(bubble(), 1'b0, 1'b0);
      advance();
    end
  endtask

  function automatic ins_t randIns();
    ins_t i;
    i     = mk(kind_t'($urandom_range(1, 16)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
    i.imm = $urandom;
    return i;
  endfunction

  initial begin
    ins_t nxt;
    bit   nv, hold, fl;

    rst = 1'b1; instr_id = 32'h0; id_valid = 1'b0; br_taken_ex = 1'b0;
    modelReset();
    m_id = bubble();
    @(posedge clk); #1;

    // Reset state
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("rst_wb_we", 32'(wb_we), 32'd0);
    checkField("rst_md_busy", 32'(md_busy), 32'd0);
    advance();
    rst = 1'b0;

    // ADDU r3,r1,r2 writes back three cycles later, no stall
    applyStimulus(mk(K_ADDU, 1, 2, 3), 1'b1, 1'b0);
    checkField("t1_stall", 32'(stall), 32'd0);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t1_wb_we", 32'(wb_we), 32'd1);
    checkField("t1_wb_addr", 32'(wb_addr), 32'd3);
    checkField("t1_wb_sel", 32'(wb_sel), 32'd0);
    advance();

    // LW r5,0(r1) then ADDU r6,r5,r2: one stall cycle, WB five cycles after LW
    applyStimulus(mk(K_LW, 1, 5, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_ADDU, 5, 2, 6), 1'b1, 1'b0);
    checkField("t2_stall", 32'(stall), 32'd1);
    checkField("t2_nohaz_stall", 32'(nh_stall), 32'd0);
    advance();
    applyStimulus(mk(K_ADDU, 5, 2, 6), 1'b1, 1'b0);
    checkField("t2_stall_clear", 32'(stall), 32'd0);
    checkField("t2_mem_re", 32'(mem_re), 32'd1);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t2_wb_addr", 32'(wb_addr), 32'd6);
    checkField("t2_wb_we", 32'(wb_we), 32'd1);
    advance();

    // Load-use against JR: stall wins over the jump flush
    applyStimulus(mk(K_LW, 2, 4, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_JR, 4, 0, 0), 1'b1, 1'b0);
    checkField("t2j_stall", 32'(stall), 32'd1);
    checkField("t2j_flush", 32'(flush_if), 32'd0);
    advance();
    applyStimulus(mk(K_JR, 4, 0, 0), 1'b1, 1'b0);
    checkField("t2j_flush2", 32'(flush_if), 32'd1);
    checkField("t2j_npc", 32'(npc_op), 32'd3);
    advance();
    idle(3);

    // Taken BEQ in EX overrides a J in ID
    applyStimulus(mk(K_BEQ, 1, 2, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_J, 0, 0, 0), 1'b1, 1'b1);
    checkField("t3_flush", 32'(flush_if), 32'd1);
    checkField("t3_npc", 32'(npc_op), 32'd1);
    advance();
    idle(1);
    // Same with JAL so a leaked jump would show up as a r31 write
    applyStimulus(mk(K_BEQ, 1, 2, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_JAL, 0, 0, 0), 1'b1, 1'b1);
    checkField("t3_npc_jal", 32'(npc_op), 32'd1);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t3_no_link", 32'(wb_we), 32'd0);
    advance();

    // MULTU then MFLO r7: busy exactly MD_LAT cycles, MFLO held until it falls
    applyStimulus(mk(K_MULTU, 1, 2, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_MFLO, 0, 0, 7), 1'b1, 1'b0);
    checkField("t4_md_start", 32'(ex_md_start), 32'd1);
    checkField("t4_stall0", 32'(stall), 32'd1);
    advance();
    for (int c = 0; c < MD_LAT; c++) begin
      applyStimulus(mk(K_MFLO, 0, 0, 7), 1'b1, 1'b0);
      checkField("t4_busy", 32'(md_busy), 32'd1);
      checkField("t4_stall", 32'(stall), 32'd1);
      advance();
    end
    applyStimulus(mk(K_MFLO, 0, 0, 7), 1'b1, 1'b0);
    checkField("t4_busy_fall", 32'(md_busy), 32'd0);
    checkField("t4_release", 32'(stall), 32'd0);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t4_wb_addr", 32'(wb_addr), 32'd7);
    checkField("t4_wb_sel", 32'(wb_sel), 32'd3);
    advance();

    // JAL links r31; ADDU to r0 never writes
    applyStimulus(mk(K_JAL, 0, 0, 0), 1'b1, 1'b0);
    checkField("t5_flush", 32'(flush_if), 32'd1);
    checkField("t5_npc", 32'(npc_op), 32'd2);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t5_wb_addr", 32'(wb_addr), 32'd31);
    checkField("t5_wb_sel", 32'(wb_sel), 32'd2);
    advance();
    applyStimulus(mk(K_ADDU, 1, 2, 0), 1'b1, 1'b0);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t5_r0_we", 32'(wb_we), 32'd0);
    advance();

    // Asynchronous reset in the middle of a MULTU stall
    applyStimulus(mk(K_MULTU, 3, 1, 0), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_MFLO, 0, 0, 9), 1'b1, 1'b0);
    advance();
    applyStimulus(mk(K_MFLO, 0, 0, 9), 1'b1, 1'b0);
    checkField("t6_busy_pre", 32'(md_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    computeComb();
    checkOutput();
    checkField("t6_busy_rst", 32'(md_busy), 32'd0);
    checkField("t6_stall_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(mk(K_MFLO, 0, 0, 9), 1'b1, 1'b0);
    advance();
    idle(2);
    applyStimulus(bubble(), 1'b0, 1'b0);
    checkField("t6_wb_addr", 32'(wb_addr), 32'd9);
    advance();

    // Random instruction stream; the bench plays the fetch stage
    nxt = bubble();
    nv  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      applyStimulus(nxt, nv, 1'($urandom_range(0, 1)));
      hold = e_stall;
      fl   = e_flush;
      advance();
      if (!hold) begin
        if (fl) begin
          nxt = bubble();
          nv  = 1'b0;
        end else begin
          nxt = randIns();
          nv  = ($urandom_range(0, 7) != 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
